// File: rtl/fp_exception_result_packer.sv
// fp_exception_result_packer: packs multiplier fields/exception flags into an IEEE single,
// queues it in a small valid/ready FIFO, and tracks sticky flags plus a saturating exception count.
module fp_exception_result_packer #(
   parameter int          DEPTH = 2,
   parameter int          CNT_W = 16,
   parameter logic [31:0] QNAN  = 32'h7FC00000,
   parameter bit          FTZ   = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sign_z,
   input  logic [7:0]       Ez,
   input  logic [22:0]      Mz,
   input  logic             invalid_flag,
   input  logic             overflow_flag,
   input  logic             initial_zero_flag,
   input  logic             underflow_flag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic [3:0]       result_flags,
   output logic [3:0]       sticky_flags,
   input  logic             flag_clear,
   output logic [CNT_W-1:0] exc_count
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [35:0]      mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [AW:0]      cnt;
   logic [3:0]       flags;
   logic [31:0]      packed_word;
   logic             push, pop;
   logic [CNT_W-1:0] exc_base;
   assign flags       = {underflow_flag, initial_zero_flag, overflow_flag, invalid_flag};
   assign packed_word = invalid_flag ? QNAN :
                        overflow_flag ? {sign_z, 8'hFF, 23'h0} :
                        (initial_zero_flag || (underflow_flag && FTZ)) ? {sign_z, 31'h0} :
                        {sign_z, Ez, Mz};
   assign in_ready  = cnt != (AW+1)'(DEPTH);
   assign out_valid = cnt != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   // Outputs come straight from the head entry, so they depend only on registered state.
   assign {result_flags, result} = mem[rp];
   // A clear in the same cycle as an accept wipes history before the new word is counted.
   assign exc_base = flag_clear ? '0 : exc_count;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wp           <= '0;
         rp           <= '0;
         cnt          <= '0;
         sticky_flags <= '0;
         exc_count    <= '0;
      end else begin
         if (push) mem[wp] <= {flags, packed_word};
         wp           <= wp + AW'(push);
         rp           <= rp + AW'(pop);
         cnt          <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         sticky_flags <= (flag_clear ? 4'h0 : sticky_flags) | (push ? flags : 4'h0);
         exc_count    <= exc_base + CNT_W'(push && (|flags) && !(&exc_base));
      end
   end
endmodule

// File: tb/tb_fp_exception_result_packer.sv
// tb_fp_exception_result_packer: scenario tasks plus a queue scoreboard checking every popped word.
module tb_fp_exception_result_packer;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        in_valid = 1'b0, sign_z = 1'b0, out_ready = 1'b1, flag_clear = 1'b0;
   logic [7:0]  Ez = '0;
   logic [22:0] Mz = '0;
   logic [3:0]  fl = '0;
   logic        in_ready, out_valid, in_ready_nf, out_valid_nf, in_ready_c2, out_valid_c2;
   logic [31:0] result, result_nf, result_c2;
   logic [3:0]  result_flags, sticky_flags, rf_nf, sf_nf, rf_c2, sf_c2;
   logic [15:0] exc_count, exc_nf;
   logic [1:0]  exc_c2;
   int tests = 0, fails = 0;
   logic [35:0] q_exp [$];
   logic [31:0] q_nf [$];

   always #5 CLK = ~CLK;

   fp_exception_result_packer dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .sign_z(sign_z), .Ez(Ez), .Mz(Mz),
      .invalid_flag(fl[0]), .overflow_flag(fl[1]), .initial_zero_flag(fl[2]), .underflow_flag(fl[3]),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_flags(result_flags),
      .sticky_flags(sticky_flags), .flag_clear(flag_clear), .exc_count(exc_count));
   fp_exception_result_packer #(.FTZ(1'b0)) dut_nf (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_nf), .sign_z(sign_z), .Ez(Ez), .Mz(Mz),
      .invalid_flag(fl[0]), .overflow_flag(fl[1]), .initial_zero_flag(fl[2]), .underflow_flag(fl[3]),
      .out_valid(out_valid_nf), .out_ready(out_ready), .result(result_nf), .result_flags(rf_nf),
      .sticky_flags(sf_nf), .flag_clear(flag_clear), .exc_count(exc_nf));
   fp_exception_result_packer #(.CNT_W(2)) dut_c2 (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_c2), .sign_z(sign_z), .Ez(Ez), .Mz(Mz),
      .invalid_flag(fl[0]), .overflow_flag(fl[1]), .initial_zero_flag(fl[2]), .underflow_flag(fl[3]),
      .out_valid(out_valid_c2), .out_ready(out_ready), .result(result_c2), .result_flags(rf_c2),
      .sticky_flags(sf_c2), .flag_clear(flag_clear), .exc_count(exc_c2));

   function automatic logic [31:0] model(input bit ftz, input logic s, input logic [7:0] e,
                                         input logic [22:0] m, input logic [3:0] f);
      if (f[0]) return 32'h7FC00000;
      if (f[1]) return {s, 8'hFF, 23'h0};
      if (f[2] || (f[3] && ftz)) return {s, 31'h0};
      return {s, e, m};
   endfunction

   // Inputs change 1 time unit after the rising edge, so the negedge view equals the next edge's view.
   always @(negedge CLK) begin
      if (RST) begin
         q_exp.delete();
         q_nf.delete();
      end else begin
         if (out_valid && out_ready) begin
            tests++;
            if (q_exp.size() == 0) begin
               fails++;
               $display("FAIL scoreboard_underrun got result=%h expected no output", result);
            end else begin
               logic [35:0] e;
               logic [31:0] enf;
               e   = q_exp.pop_front();
               enf = q_nf.pop_front();
               if ({result_flags, result} !== e) begin
                  fails++;
                  $display("FAIL scoreboard_word got %h/%h expected %h/%h", result_flags, result, e[35:32], e[31:0]);
               end
               tests++;
               if (result_nf !== enf) begin
                  fails++;
                  $display("FAIL scoreboard_noftz got %h expected %h", result_nf, enf);
               end
            end
         end
         if (in_valid && in_ready) begin
            q_exp.push_back({fl, model(1'b1, sign_z, Ez, Mz, fl)});
            q_nf.push_back(model(1'b0, sign_z, Ez, Mz, fl));
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [22:0] m, input logic [3:0] f);
      in_valid = v;
      sign_z   = s;
      Ez       = e;
      Mz       = m;
      fl       = f;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      tests++;
      if ({out_valid, in_ready, result, result_flags, sticky_flags, exc_count} !== {1'b0, 1'b1, 32'h0, 4'h0, 4'h0, 16'h0}) begin
         fails++;
         $display("FAIL reset_state got ov=%b ir=%b res=%h rf=%h sf=%h cnt=%0d", out_valid, in_ready, result, result_flags, sticky_flags, exc_count);
      end
      RST = 1'b0;
      step();
   endtask

   task automatic test_normal();
      out_ready = 1'b1;
      drive(1, 0, 8'h80, 23'h400000, 4'h0);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL normal_pre_valid got %b expected 0", out_valid);
      end
      step();
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      tests++;
      if (out_valid !== 1'b1 || result !== 32'h40400000) begin
         fails++;
         $display("FAIL normal_word got ov=%b res=%h expected 1/40400000", out_valid, result);
      end
      step();
   endtask

   task automatic test_priority();
      drive(1, 0, 8'h12, 23'h3, 4'b0011);
      step();
      tests++;
      if (result !== 32'h7FC00000 || result_flags !== 4'b0011) begin
         fails++;
         $display("FAIL priority_inv got %h/%b expected 7fc00000/0011", result, result_flags);
      end
      drive(1, 1, 8'h12, 23'h3, 4'b0010);
      step();
      tests++;
      if (result !== 32'hFF800000 || result_flags !== 4'b0010) begin
         fails++;
         $display("FAIL priority_ovf got %h/%b expected ff800000/0010", result, result_flags);
      end
      drive(1, 1, 8'h40, 23'h7, 4'b1100);
      step();
      tests++;
      if (result !== 32'h80000000 || result_flags !== 4'b1100) begin
         fails++;
         $display("FAIL priority_zero got %h/%b expected 80000000/1100", result, result_flags);
      end
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      step();
   endtask

   task automatic test_underflow();
      drive(1, 1, 8'h00, 23'h5, 4'b1000);
      step();
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      tests++;
      if (result !== 32'h80000000 || result_nf !== 32'h80000005) begin
         fails++;
         $display("FAIL underflow got ftz=%h noftz=%h expected 80000000/80000005", result, result_nf);
      end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1, 0, 8'h81, 23'h1, 4'h0);
      step();
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_ready_one got %b expected 1", in_ready);
      end
      drive(1, 0, 8'h82, 23'h2, 4'h0);
      step();
      drive(1, 1, 8'h83, 23'h3, 4'h0);
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_full got in_ready=%b expected 0", in_ready);
      end
      step();
      step();
      tests++;
      if (result !== 32'h40800001 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_hold got %h ir=%b expected 40800001/0", result, in_ready);
      end
      out_ready = 1'b1;
      step();
      tests++;
      if (result !== 32'h41000002) begin
         fails++;
         $display("FAIL bp_second got %h expected 41000002", result);
      end
      step();
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      tests++;
      if (result !== 32'hC1800003) begin
         fails++;
         $display("FAIL bp_third got %h expected c1800003", result);
      end
      step();
      tests++;
      if (out_valid !== 1'b0 || q_exp.size() != 0) begin
         fails++;
         $display("FAIL bp_drain got ov=%b queued=%0d expected 0/0", out_valid, q_exp.size());
      end
   endtask

   task automatic test_sticky();
      flag_clear = 1'b1;
      step();
      flag_clear = 1'b0;
      drive(1, 0, 8'h1, 23'h1, 4'b0001);
      step();
      drive(1, 0, 8'h1, 23'h1, 4'b0010);
      step();
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      tests++;
      if (sticky_flags !== 4'b0011 || exc_count !== 16'd2) begin
         fails++;
         $display("FAIL sticky_accum got %b/%0d expected 0011/2", sticky_flags, exc_count);
      end
      flag_clear = 1'b1;
      drive(1, 0, 8'h1, 23'h1, 4'b0100);
      step();
      flag_clear = 1'b0;
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      tests++;
      if (sticky_flags !== 4'b0100 || exc_count !== 16'd1) begin
         fails++;
         $display("FAIL sticky_clear_accept got %b/%0d expected 0100/1", sticky_flags, exc_count);
      end
      flag_clear = 1'b1;
      step();
      flag_clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, i[0], 8'h3, 23'(i), 4'b1000);
         step();
      end
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      tests++;
      if (exc_c2 !== 2'd3 || exc_count !== 16'd5 || sticky_flags !== 4'b1000) begin
         fails++;
         $display("FAIL count_saturate got c2=%0d c16=%0d sf=%b expected 3/5/1000", exc_c2, exc_count, sticky_flags);
      end
      step();
   endtask

   task automatic test_reset_midop();
      out_ready = 1'b0;
      drive(1, 0, 8'h90, 23'h10, 4'b0001);
      step();
      drive(1, 0, 8'h91, 23'h11, 4'h0);
      step();
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL midop_full got ov=%b ir=%b expected 1/0", out_valid, in_ready);
      end
      #2 RST = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || exc_count !== 16'h0) begin
         fails++;
         $display("FAIL midop_async got ov=%b ir=%b res=%h cnt=%0d expected 0/1/0/0", out_valid, in_ready, result, exc_count);
      end
      step();
      RST = 1'b0;
      out_ready = 1'b1;
      step();
      drive(1, 1, 8'h7F, 23'h1, 4'h0);
      step();
      drive(0, 0, 8'h0, 23'h0, 4'h0);
      tests++;
      if (out_valid !== 1'b1 || result !== 32'hBF800001) begin
         fails++;
         $display("FAIL midop_restart got ov=%b res=%h expected 1/bf800001", out_valid, result);
      end
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_priority();
      test_underflow();
      test_backpressure();
      test_sticky();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
